// File: rtl/mem_wr_pkg.sv
// mem_wr_pkg: shared widths and the store-buffer entry layout for the
// writeback stage.
//   XLEN       data/address width
//   REG_IDX_W  register-file index width
//   STRB_W     byte-strobe width
//   sb_entry_t one store-buffer entry {addr, strb, data}
//   SB_ENTRY_W packed width of sb_entry_t (68)
package mem_wr_pkg;

  localparam int XLEN      = 32;
  localparam int REG_IDX_W = 5;
  localparam int STRB_W    = 4;

  typedef struct packed {
    logic [XLEN-1:0]   addr;
    logic [STRB_W-1:0] strb;
    logic [XLEN-1:0]   data;
  } sb_entry_t;

  localparam int SB_ENTRY_W = $bits(sb_entry_t);

endpackage

// File: rtl/mem_wr_store_buf_fifo.sv
// store_buf_fifo: small synchronous FIFO with asynchronous active-high reset.
// Ports:
//   clk, rst        clock / async reset (active high)
//   push, wdata     write an entry (ignored while full)
//   pop             advance the head (ignored while empty)
//   full, empty     occupancy flags
//   head            current head entry, combinational from storage
module store_buf_fifo
  import mem_wr_pkg::*;
#(
  parameter int WIDTH = SB_ENTRY_W,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int AW    = $clog2(DEPTH);
  localparam int PTR_W = AW + 1;

  // One extra pointer bit distinguishes full from empty when low bits match.
  logic [PTR_W-1:0] wp;
  logic [PTR_W-1:0] rp;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign empty   = (wp == rp);
  assign full    = (wp[PTR_W-1] != rp[PTR_W-1]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rp[AW-1:0]];

  // Storage is cleared on reset so the head reads as zero immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wp[AW-1:0]] <= wdata;
        wp              <= wp + PTR_W'(1);
      end
      if (do_pop) begin
        rp <= rp + PTR_W'(1);
      end
    end
  end

endmodule

// File: rtl/mem_wr.sv
// mem_wr: final pipeline stage. Registers the mem_rd results into the
// writeback registers and drains committed stores to data memory through an
// in-order store buffer with a valid/ready write port.
// Ports:
//   CLK, RST                      clock / async reset (active high)
//   STALL                         global pipeline stall
//   M_PC, M_INST, M_VALID         instruction from mem_rd
//   M_REG_D, M_REG_D_V            destination index / value
//   M_STORE_WREN/ADDR/STRB/DATA   store request
//   W_PC, W_INST, W_VALID         retired instruction (trace)
//   W_REG_D, W_REG_D_V, W_REG_WREN register-file write port
//   STALL_REQ                     store buffer full with a store waiting
//   STORE_PENDING                 store buffer non-empty
//   DATA_WR_VALID/READY           data-memory write handshake
//   DATA_WR_ADDR/STRB/DATA        head store-buffer entry
module mem_wr
  import mem_wr_pkg::*;
#(
  parameter int SB_DEPTH = 2
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 STALL,
  input  logic [XLEN-1:0]      M_PC,
  input  logic [XLEN-1:0]      M_INST,
  input  logic                 M_VALID,
  input  logic [REG_IDX_W-1:0] M_REG_D,
  input  logic [XLEN-1:0]      M_REG_D_V,
  input  logic                 M_STORE_WREN,
  input  logic [XLEN-1:0]      M_STORE_ADDR,
  input  logic [STRB_W-1:0]    M_STORE_STRB,
  input  logic [XLEN-1:0]      M_STORE_DATA,
  output logic [XLEN-1:0]      W_PC,
  output logic [XLEN-1:0]      W_INST,
  output logic                 W_VALID,
  output logic [REG_IDX_W-1:0] W_REG_D,
  output logic [XLEN-1:0]      W_REG_D_V,
  output logic                 W_REG_WREN,
  output logic                 STALL_REQ,
  output logic                 STORE_PENDING,
  output logic                 DATA_WR_VALID,
  input  logic                 DATA_WR_READY,
  output logic [XLEN-1:0]      DATA_WR_ADDR,
  output logic [STRB_W-1:0]    DATA_WR_STRB,
  output logic [XLEN-1:0]      DATA_WR_DATA
);

  sb_entry_t push_entry;
  sb_entry_t head_entry;
  logic      sb_full;
  logic      sb_empty;
  logic      push;
  logic      pop;

  assign push_entry = '{addr: M_STORE_ADDR, strb: M_STORE_STRB, data: M_STORE_DATA};
  assign push       = !STALL && M_VALID && M_STORE_WREN;
  assign pop        = DATA_WR_VALID && DATA_WR_READY;

  store_buf_fifo #(
    .WIDTH (SB_ENTRY_W),
    .DEPTH (SB_DEPTH)
  ) u_store_buf (
    .clk   (CLK),
    .rst   (RST),
    .push  (push),
    .wdata (push_entry),
    .pop   (pop),
    .full  (sb_full),
    .empty (sb_empty),
    .head  (head_entry)
  );

  assign DATA_WR_VALID = !sb_empty;
  assign STORE_PENDING = !sb_empty;
  assign DATA_WR_ADDR  = head_entry.addr;
  assign DATA_WR_STRB  = head_entry.strb;
  assign DATA_WR_DATA  = head_entry.data;

  // Deliberately independent of STALL: this signal feeds the stall logic.
  // A pop in the same cycle does not drop it; the push simply lands next cycle.
  assign STALL_REQ = sb_full && M_VALID && M_STORE_WREN;

  // On stall only the valid drops; the payload holds so a stalled instruction
  // retires exactly once when the stall clears.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      W_PC       <= '0;
      W_INST     <= '0;
      W_VALID    <= 1'b0;
      W_REG_D    <= '0;
      W_REG_D_V  <= '0;
      W_REG_WREN <= 1'b0;
    end else if (STALL) begin
      W_VALID    <= 1'b0;
      W_REG_WREN <= 1'b0;
    end else begin
      W_PC       <= M_PC;
      W_INST     <= M_INST;
      W_VALID    <= M_VALID;
      W_REG_D    <= M_REG_D;
      W_REG_D_V  <= M_REG_D_V;
      W_REG_WREN <= M_VALID && (M_REG_D != '0);
    end
  end

endmodule

// File: tb/tb_mem_wr.sv
module tb_mem_wr;

  logic        CLK = 1'b0;
  logic        RST;
  logic        STALL;
  logic [31:0] M_PC, M_INST;
  logic        M_VALID;
  logic [4:0]  M_REG_D;
  logic [31:0] M_REG_D_V;
  logic        M_STORE_WREN;
  logic [31:0] M_STORE_ADDR;
  logic [3:0]  M_STORE_STRB;
  logic [31:0] M_STORE_DATA;
  logic [31:0] W_PC, W_INST;
  logic        W_VALID;
  logic [4:0]  W_REG_D;
  logic [31:0] W_REG_D_V;
  logic        W_REG_WREN;
  logic        STALL_REQ;
  logic        STORE_PENDING;
  logic        DATA_WR_VALID;
  logic        DATA_WR_READY;
  logic [31:0] DATA_WR_ADDR;
  logic [3:0]  DATA_WR_STRB;
  logic [31:0] DATA_WR_DATA;

  int n_assert = 0;
  int n_fail   = 0;

  mem_wr #(.SB_DEPTH(2)) dut (
    .CLK(CLK), .RST(RST), .STALL(STALL),
    .M_PC(M_PC), .M_INST(M_INST), .M_VALID(M_VALID),
    .M_REG_D(M_REG_D), .M_REG_D_V(M_REG_D_V),
    .M_STORE_WREN(M_STORE_WREN), .M_STORE_ADDR(M_STORE_ADDR),
    .M_STORE_STRB(M_STORE_STRB), .M_STORE_DATA(M_STORE_DATA),
    .W_PC(W_PC), .W_INST(W_INST), .W_VALID(W_VALID),
    .W_REG_D(W_REG_D), .W_REG_D_V(W_REG_D_V), .W_REG_WREN(W_REG_WREN),
    .STALL_REQ(STALL_REQ), .STORE_PENDING(STORE_PENDING),
    .DATA_WR_VALID(DATA_WR_VALID), .DATA_WR_READY(DATA_WR_READY),
    .DATA_WR_ADDR(DATA_WR_ADDR), .DATA_WR_STRB(DATA_WR_STRB),
    .DATA_WR_DATA(DATA_WR_DATA)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_alu(input logic [31:0] pc, input logic [4:0] rd, input logic [31:0] v);
    M_VALID = 1'b1; M_STORE_WREN = 1'b0;
    M_PC = pc; M_INST = 32'h0000_0013; M_REG_D = rd; M_REG_D_V = v;
  endtask

  task automatic set_store(input logic [31:0] pc, input logic [31:0] a, input logic [3:0] s,
                           input logic [31:0] d);
    M_VALID = 1'b1; M_STORE_WREN = 1'b1;
    M_PC = pc; M_INST = 32'h0000_2023; M_REG_D = 5'd0; M_REG_D_V = 32'h0;
    M_STORE_ADDR = a; M_STORE_STRB = s; M_STORE_DATA = d;
  endtask

  task automatic idle();
    M_VALID = 1'b0; M_STORE_WREN = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_w_pc"},      W_PC, 32'h0);
    chk({tag, "_w_inst"},    W_INST, 32'h0);
    chk({tag, "_w_valid"},   32'(W_VALID), 32'h0);
    chk({tag, "_w_reg_d"},   32'(W_REG_D), 32'h0);
    chk({tag, "_w_reg_d_v"}, W_REG_D_V, 32'h0);
    chk({tag, "_w_wren"},    32'(W_REG_WREN), 32'h0);
    chk({tag, "_stall_req"}, 32'(STALL_REQ), 32'h0);
    chk({tag, "_pending"},   32'(STORE_PENDING), 32'h0);
    chk({tag, "_wr_valid"},  32'(DATA_WR_VALID), 32'h0);
    chk({tag, "_wr_addr"},   DATA_WR_ADDR, 32'h0);
    chk({tag, "_wr_strb"},   32'(DATA_WR_STRB), 32'h0);
    chk({tag, "_wr_data"},   DATA_WR_DATA, 32'h0);
  endtask

  initial begin
    RST = 1'b1; STALL = 1'b0; DATA_WR_READY = 1'b0;
    M_PC = '0; M_INST = '0; M_VALID = 1'b0; M_REG_D = '0; M_REG_D_V = '0;
    M_STORE_WREN = 1'b0; M_STORE_ADDR = '0; M_STORE_STRB = '0; M_STORE_DATA = '0;
    #2;
    chk_all_zero("init_rst");
    tick(); tick();
    RST = 1'b0;
    tick();
    chk("rel_wr_valid", 32'(DATA_WR_VALID), 32'h0);

    // ALU retire, nonzero and zero destination
    set_alu(32'h40, 5'd5, 32'h1234);
    tick();
    chk("alu_w_valid", 32'(W_VALID), 32'h1);
    chk("alu_w_wren",  32'(W_REG_WREN), 32'h1);
    chk("alu_w_reg_d", 32'(W_REG_D), 32'h5);
    chk("alu_w_val",   W_REG_D_V, 32'h1234);
    chk("alu_w_pc",    W_PC, 32'h40);
    set_alu(32'h44, 5'd0, 32'h55);
    tick();
    chk("x0_w_valid", 32'(W_VALID), 32'h1);
    chk("x0_w_wren",  32'(W_REG_WREN), 32'h0);
    idle();
    tick();
    chk("bubble_w_valid", 32'(W_VALID), 32'h0);

    // Single store with READY high
    DATA_WR_READY = 1'b1;
    set_store(32'h48, 32'h100, 4'hF, 32'hDEADBEEF);
    tick();
    idle();
    chk("st1_valid",   32'(DATA_WR_VALID), 32'h1);
    chk("st1_addr",    DATA_WR_ADDR, 32'h100);
    chk("st1_strb",    32'(DATA_WR_STRB), 32'hF);
    chk("st1_data",    DATA_WR_DATA, 32'hDEADBEEF);
    chk("st1_pending", 32'(STORE_PENDING), 32'h1);
    chk("st1_w_wren",  32'(W_REG_WREN), 32'h0);
    tick();
    chk("st1_drained", 32'(DATA_WR_VALID), 32'h0);
    chk("st1_pend_off", 32'(STORE_PENDING), 32'h0);
    tick();
    chk("st1_stay_empty", 32'(STORE_PENDING), 32'h0);

    // Backpressure: three stores with READY low
    DATA_WR_READY = 1'b0;
    set_store(32'h50, 32'h100, 4'h1, 32'hA0);
    tick();
    chk("bp1_valid", 32'(DATA_WR_VALID), 32'h1);
    chk("bp1_addr",  DATA_WR_ADDR, 32'h100);
    set_store(32'h54, 32'h104, 4'h3, 32'hA4);
    chk("bp2_no_req", 32'(STALL_REQ), 32'h0);
    tick();
    set_store(32'h58, 32'h108, 4'hC, 32'hA8);
    #0;
    chk("bp3_req", 32'(STALL_REQ), 32'h1);
    STALL = STALL_REQ;
    tick();
    chk("bp3_w_valid", 32'(W_VALID), 32'h0);
    chk("bp3_req_hold", 32'(STALL_REQ), 32'h1);
    chk("bp3_addr_stable", DATA_WR_ADDR, 32'h100);
    tick();
    chk("bp3_w_valid2", 32'(W_VALID), 32'h0);
    chk("bp3_addr_stable2", DATA_WR_ADDR, 32'h100);
    chk("bp3_data_stable2", DATA_WR_DATA, 32'hA0);

    // Full with a store waiting and READY high in the same cycle
    DATA_WR_READY = 1'b1;
    #0;
    chk("fp_req_same_cycle", 32'(STALL_REQ), 32'h1);
    tick();
    DATA_WR_READY = 1'b0;
    chk("fp_head_104", DATA_WR_ADDR, 32'h104);
    chk("fp_req_clear", 32'(STALL_REQ), 32'h0);
    STALL = 1'b0;
    tick();
    chk("fp_retire_once", 32'(W_VALID), 32'h1);
    chk("fp_retire_pc", W_PC, 32'h58);
    set_store(32'h5C, 32'h10C, 4'hF, 32'hAC);
    #0;
    chk("fp_full_again", 32'(STALL_REQ), 32'h1);
    STALL = 1'b1;
    tick();
    chk("fp_no_retire", 32'(W_VALID), 32'h0);
    idle();
    STALL = 1'b0;
    DATA_WR_READY = 1'b1;
    #0;
    chk("drain0_addr", DATA_WR_ADDR, 32'h104);
    chk("drain0_strb", 32'(DATA_WR_STRB), 32'h3);
    tick();
    chk("drain1_valid", 32'(DATA_WR_VALID), 32'h1);
    chk("drain1_addr",  DATA_WR_ADDR, 32'h108);
    chk("drain1_data",  DATA_WR_DATA, 32'hA8);
    tick();
    chk("drain2_empty", 32'(DATA_WR_VALID), 32'h0);

    // Reset mid-drain, asserted between clock edges
    DATA_WR_READY = 1'b0;
    set_store(32'h60, 32'h300, 4'hF, 32'h11);
    M_REG_D = 5'd7; M_REG_D_V = 32'h77;
    tick();
    set_store(32'h64, 32'h304, 4'hF, 32'h22);
    M_REG_D = 5'd7; M_REG_D_V = 32'h77;
    tick();
    chk("md_pre_valid", 32'(DATA_WR_VALID), 32'h1);
    chk("md_pre_w_valid", 32'(W_VALID), 32'h1);
    #3;
    RST = 1'b1;
    #1;
    chk_all_zero("md_rst");
    RST = 1'b0;
    idle();
    tick();
    chk("md_rel_valid", 32'(DATA_WR_VALID), 32'h0);
    DATA_WR_READY = 1'b1;
    set_store(32'h68, 32'h200, 4'hF, 32'h2200);
    tick();
    idle();
    chk("md_new_valid", 32'(DATA_WR_VALID), 32'h1);
    chk("md_new_addr",  DATA_WR_ADDR, 32'h200);
    chk("md_new_data",  DATA_WR_DATA, 32'h2200);
    tick();
    chk("md_new_drained", 32'(DATA_WR_VALID), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
